// File: rtl/aes_ladder_arbiter.sv
`default_nettype none
// aes_ladder_arbiter: round-robin share of one sequential AES round ladder among N_REQ requesters.
// Rev 1.0
module aes_ladder_arbiter #(
  parameter int NB_DATA  = 128,
  parameter int N_REQ    = 2,
  parameter int NB_ID    = 1,
  parameter int TIMEOUT  = 20,
  parameter int NB_TIMER = 5
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_valid,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ*NB_DATA-1:0] i_req_data,
  output logic [N_REQ-1:0]         o_ack,
  output logic                     o_busy,
  output logic [NB_DATA-1:0]       o_ladder_state,
  output logic                     o_ladder_trigger,
  input  logic [NB_DATA-1:0]       i_ladder_state,
  input  logic                     i_ladder_ready,
  output logic [NB_DATA-1:0]       o_result,
  output logic                     o_result_valid,
  output logic [NB_ID-1:0]         o_result_id,
  output logic                     o_timeout_error
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t               r_state;
  logic [NB_ID-1:0]     r_last_grant;
  logic [NB_TIMER-1:0]  r_timer;
  logic [NB_DATA-1:0]   r_hold;
  logic [N_REQ-1:0]     r_ack;
  logic                 r_trigger;
  logic [NB_DATA-1:0]   r_result;
  logic                 r_result_valid;
  logic [NB_ID-1:0]     r_result_id;
  logic                 r_timeout;

  logic                 w_found;
  logic [NB_ID-1:0]     w_winner;
  logic [N_REQ-1:0]     w_ack_oh;
  logic [NB_DATA-1:0]   w_data;

  // Search starts one past the last grant and wraps; the first set request wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (!w_found && i_req[k] && (k == (int'(r_last_grant) + i) % N_REQ)) begin
          w_found  = 1'b1;
          w_winner = NB_ID'(k);
        end
      end
    end
  end

  always_comb begin
    w_ack_oh = '0;
    w_data   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_winner == NB_ID'(k)) begin
        w_ack_oh[k] = 1'b1;
        w_data      = i_req_data[k*NB_DATA +: NB_DATA];
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_last_grant   <= NB_ID'(N_REQ - 1);
      r_timer        <= '0;
      r_hold         <= '0;
      r_ack          <= '0;
      r_trigger      <= 1'b0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_result_id    <= '0;
      r_timeout      <= 1'b0;
    end else if (i_valid) begin
      r_ack          <= '0;
      r_trigger      <= 1'b0;
      r_result_valid <= 1'b0;
      r_timeout      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_hold       <= w_data;
            r_ack        <= w_ack_oh;
            r_result_id  <= w_winner;
            r_last_grant <= w_winner;
            r_trigger    <= 1'b1;
            r_state      <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_timer <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_timer <= r_timer + 1'b1;
          // A ready on the last allowed cycle still counts as success.
          if (i_ladder_ready) begin
            r_result       <= i_ladder_state;
            r_result_valid <= 1'b1;
            r_state        <= S_DONE;
          end else if (r_timer == NB_TIMER'(TIMEOUT - 1)) begin
            r_timeout <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy           = (r_state != S_IDLE);
  assign o_ack            = r_ack;
  assign o_ladder_state   = r_hold;
  assign o_ladder_trigger = r_trigger;
  assign o_result         = r_result;
  assign o_result_valid   = r_result_valid;
  assign o_result_id      = r_result_id;
  assign o_timeout_error  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_aes_ladder_arbiter.sv
`default_nettype none
// tb_aes_ladder_arbiter: scoreboard bench with a behavioural ladder of programmable latency.
// Rev 1.0
module tb_aes_ladder_arbiter;

  localparam int NB_DATA  = 128;
  localparam int N_REQ    = 2;
  localparam int NB_ID    = 1;
  localparam int TIMEOUT  = 20;
  localparam int NB_TIMER = 5;
  localparam int NEVER    = 1000;

  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] D0 = 128'hdeadbeef_01234567_89abcdef_cafef00d;
  localparam logic [127:0] D1 = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;

  logic                     clk = 1'b0;
  logic                     i_reset;
  logic                     i_valid;
  logic [N_REQ-1:0]         i_req;
  logic [N_REQ*NB_DATA-1:0] i_req_data;
  logic [N_REQ-1:0]         o_ack;
  logic                     o_busy;
  logic [NB_DATA-1:0]       o_ladder_state;
  logic                     o_ladder_trigger;
  logic [NB_DATA-1:0]       i_ladder_state;
  logic                     i_ladder_ready;
  logic [NB_DATA-1:0]       o_result;
  logic                     o_result_valid;
  logic [NB_ID-1:0]         o_result_id;
  logic                     o_timeout_error;

  always #5 clk = ~clk;

  aes_ladder_arbiter #(
    .NB_DATA(NB_DATA), .N_REQ(N_REQ), .NB_ID(NB_ID), .TIMEOUT(TIMEOUT), .NB_TIMER(NB_TIMER)
  ) dut (
    .i_clock          (clk),
    .i_reset          (i_reset),
    .i_valid          (i_valid),
    .i_req            (i_req),
    .i_req_data       (i_req_data),
    .o_ack            (o_ack),
    .o_busy           (o_busy),
    .o_ladder_state   (o_ladder_state),
    .o_ladder_trigger (o_ladder_trigger),
    .i_ladder_state   (i_ladder_state),
    .i_ladder_ready   (i_ladder_ready),
    .o_result         (o_result),
    .o_result_valid   (o_result_valid),
    .o_result_id      (o_result_id),
    .o_timeout_error  (o_timeout_error)
  );

  typedef struct {
    bit           is_to;
    int           id;
    logic [127:0] data;
  } exp_t;

  exp_t         ack_q[$];
  exp_t         res_q[$];
  int           total = 0;
  int           bad   = 0;
  int           n_done = 0;
  int           lat = 16;
  bit           toggle = 1'b0;
  bit           lad_active = 1'b0;
  int           lad_cnt = 0;
  logic [127:0] lad_hold = '0;
  int           wcnt = 0;
  int           rcnt = 0;
  int           ntrig = 0;
  logic [127:0] last_res = '0;
  logic [4:0]   prev_pulses = '0;

  // Known-answer stand-in for the AES-256 ladder; other blocks get a cheap bijection.
  function automatic logic [127:0] lfn(input logic [127:0] x);
    if (x == PT) return CT;
    return ~{x[63:0], x[127:64]};
  endfunction

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_op(input int id, input logic [127:0] data, input bit is_to);
    exp_t e;
    e.is_to = 1'b0;
    e.id    = id;
    e.data  = data;
    ack_q.push_back(e);
    e.is_to = is_to;
    e.data  = lfn(data);
    res_q.push_back(e);
  endtask

  task automatic monitor(input bit v_last);
    exp_t             e;
    logic [N_REQ-1:0] oh;
    int               exp_w;
    rcnt++;
    if (!v_last) begin
      check_val("hold_pulses", {o_ack, o_ladder_trigger, o_result_valid, o_timeout_error}, prev_pulses);
      return;
    end
    if (o_ladder_trigger) begin
      wcnt = 0;
      rcnt = 0;
      ntrig++;
    end else begin
      wcnt++;
    end
    if (o_ack != '0) begin
      if (ack_q.size() == 0) begin
        check_val("ack_unexpected", o_ack, '0);
      end else begin
        e  = ack_q.pop_front();
        oh = N_REQ'(1) << e.id;
        check_val("ack", o_ack, oh);
        check_val("ladder_in", o_ladder_state, e.data);
      end
    end
    if (lad_active && o_busy && !o_ladder_trigger)
      check_val("ladder_state_stable", o_ladder_state, lad_hold);
    if (o_result_valid || o_timeout_error) begin
      n_done++;
      if (res_q.size() == 0) begin
        check_val("unexpected_done", 1, 0);
      end else begin
        e     = res_q.pop_front();
        exp_w = e.is_to ? TIMEOUT + 1 : lat + 1;
        check_val("kind", o_timeout_error, e.is_to);
        check_val("both_pulses", o_result_valid & o_timeout_error, 0);
        check_val("id", o_result_id, e.id);
        check_val("result", o_result, e.is_to ? last_res : e.data);
        check_val("valid_cycles", wcnt, exp_w);
        check_val("clock_cycles", rcnt, toggle ? 2 * exp_w : exp_w);
        check_val("trig_count", ntrig, 1);
        ntrig = 0;
        if (!e.is_to) last_res = e.data;
      end
    end
    prev_pulses = {o_ack, o_ladder_trigger, o_result_valid, o_timeout_error};
  endtask

  task automatic ladder();
    i_ladder_state = lfn(o_ladder_state);
    i_ladder_ready = 1'b0;
    if (!i_valid) return;
    if (o_ladder_trigger) begin
      lad_active = 1'b1;
      lad_cnt    = 0;
      lad_hold   = o_ladder_state;
    end else if (lad_active && o_busy) begin
      if (lad_cnt == lat - 1) begin
        i_ladder_ready = 1'b1;
        lad_active     = 1'b0;
      end
      lad_cnt++;
    end
  endtask

  task automatic step();
    bit v_last;
    @(negedge clk);
    v_last = i_valid;
    monitor(v_last);
    i_valid = toggle ? ~i_valid : 1'b1;
    ladder();
  endtask

  task automatic wait_ack(input string tag);
    int k = 0;
    while (ack_q.size() != 0 && k < 40) begin
      step();
      k++;
    end
    check_val({tag, "_ack_seen"}, ack_q.size(), 0);
  endtask

  task automatic run_until(input int target, input int budget, input string tag);
    int k = 0;
    while (n_done < target && k < budget) begin
      step();
      k++;
    end
    check_val({tag, "_done"}, n_done, target);
  endtask

  task automatic clear_model();
    lad_active  = 1'b0;
    prev_pulses = '0;
    last_res    = '0;
    ntrig       = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    clear_model();
  endtask

  initial begin
    int tgt;
    i_reset        = 1'b1;
    i_valid        = 1'b0;
    i_req          = '0;
    i_req_data     = '0;
    i_ladder_state = '0;
    i_ladder_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_ctrl", {o_ack, o_ladder_trigger, o_result_valid, o_timeout_error, o_busy, o_result_id}, '0);
    check_val("rst_result", o_result, '0);
    check_val("rst_lstate", o_ladder_state, '0);
    i_reset = 1'b0;
    i_valid = 1'b1;

    // single request, known-answer block
    lat = 16;
    i_req_data[0 +: 128] = PT;
    i_req = 2'b01;
    push_op(0, PT, 1'b0);
    wait_ack("single");
    i_req = '0;
    run_until(n_done + 1, 60, "single");

    // contention: fresh round-robin pointer so requester 0 goes first
    do_reset();
    i_req_data = {D1, D0};
    i_req = 2'b11;
    push_op(0, D0, 1'b0);
    push_op(1, D1, 1'b0);
    push_op(0, D0, 1'b0);
    push_op(1, D1, 1'b0);
    tgt = n_done + 4;
    run_until(tgt, 200, "contention");
    i_req = '0;

    // ladder never answers
    lat = NEVER;
    i_req = 2'b10;
    push_op(1, D1, 1'b1);
    wait_ack("timeout");
    i_req = '0;
    run_until(n_done + 1, 60, "timeout");

    // normal service after the abort
    lat = 16;
    i_req = 2'b01;
    push_op(0, D0, 1'b0);
    wait_ack("after_to");
    i_req = '0;
    run_until(n_done + 1, 60, "after_to");

    // ready on the final allowed WAIT cycle
    lat = TIMEOUT;
    i_req = 2'b10;
    push_op(1, D1, 1'b0);
    wait_ack("last_cycle");
    i_req = '0;
    run_until(n_done + 1, 60, "last_cycle");

    // i_valid alternating
    lat = 16;
    toggle = 1'b1;
    i_req = 2'b11;
    push_op(0, D0, 1'b0);
    push_op(1, D1, 1'b0);
    tgt = n_done + 2;
    run_until(tgt, 200, "toggle");
    i_req = '0;
    repeat (4) step();
    toggle = 1'b0;
    repeat (2) step();

    // asynchronous reset while waiting on the ladder
    lat = NEVER;
    i_req = 2'b01;
    ack_q.push_back('{1'b0, 0, D0});
    wait_ack("abort");
    i_req = '0;
    repeat (5) step();
    i_reset = 1'b1;
    #1;
    check_val("abort_ctrl", {o_ack, o_ladder_trigger, o_result_valid, o_timeout_error, o_busy, o_result_id}, '0);
    check_val("abort_result", o_result, '0);
    check_val("abort_lstate", o_ladder_state, '0);
    @(negedge clk);
    i_reset = 1'b0;
    clear_model();
    lat = 16;
    i_req = 2'b10;
    push_op(1, D1, 1'b0);
    wait_ack("post_abort");
    i_req = '0;
    run_until(n_done + 1, 60, "post_abort");

    repeat (30) step();
    check_val("ack_q_empty", ack_q.size(), 0);
    check_val("res_q_empty", res_q.size(), 0);
    check_val("idle_at_end", o_busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
